lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial PRBS checker: the receive-side counterpart of the team's LFSR generator.
- Consumes a bitstream produced by a Fibonacci LFSR with the same LENGTH/TAPS and self-synchronises from the received bits, so no seed exchange is needed.
- Reports lock status and bit errors.
- Sits at the far end of a link or loopback under test; the generator's serial output feeds bit_in.

Parameters:
- LENGTH, 8, LFSR width and history depth.
- TAPS, 8'b01110001, tap vector indexed [0:LENGTH-1], same convention as the generator's Fibonacci TAPS.
- EXTEND, 0, 0: an all-zero history is illegal and blocks lock; 1: all-zero history accepted.
- LOCK_COUNT, 16, consecutive matches needed to declare lock.
- WINDOW, 64, valid bits per error-monitoring window while locked.
- UNLOCK_ERRS, 8, mismatches within one window that force loss of lock.
- CNT_W, 32, err_count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- bit_in  in  1  received serial bit
- bit_valid  in  1  bit_in qualifier; nothing advances when low
- clear_cnt  in  1  zeroes err_count (synchronous)
- locked  out  1  high while in LOCKED
- err_pulse  out  1  one-cycle pulse per mismatch while LOCKED
- err_count  out  CNT_W  saturating count of mismatches seen while LOCKED
- state  out  2  current sync state (package enum)

Behaviour:
- History register h[0:LENGTH-1]: h[0] is the newest bit. On every bit_valid it shifts, h[0] <= bit_in and h[i] <= h[i-1].
- Prediction (combinational, from the pre-shift history): pred = XOR of h[i] over all i with TAPS[i]=1. match = (bit_in == pred).
- HUNT (reset state):
  - fill_cnt counts valid bits up to LENGTH; no comparison is made.
  - When the LENGTH-th bit is received, go to VERIFY with match_cnt = 0.
- VERIFY:
  - Each valid bit is compared.
  - Match: match_cnt++.
  - Mismatch: match_cnt <= 0; state stays VERIFY. History still shifts, so the checker resynchronises automatically.
  - If EXTEND=0 and the post-shift history is all zero: match_cnt <= 0, so a stuck-at-0 line can never lock.
  - When the LOCK_COUNT-th consecutive match is received, go to LOCKED and clear the window counters.
- LOCKED:
  - Each mismatch raises err_pulse, increments err_count (saturating at all-ones) and increments win_err.
  - win_bits counts valid bits from 0 to WINDOW-1, then wraps; win_err clears on each wrap.
  - If win_err reaches UNLOCK_ERRS (including on the same bit that completes a window), go to HUNT with fill_cnt = 0.
  - err_count holds its value across loss of lock.
- All outputs are registered.
  - locked, state and err_pulse reflect a given valid bit in the cycle after that bit's clock edge.
  - err_count updates on the same edge as err_pulse.
- bit_valid low: no shift, no compare, err_pulse = 0, all counters hold.
- clear_cnt coincident with an error: the clear wins and err_count = 0.
- Reset values: state = HUNT, locked = 0, err_pulse = 0, err_count = 0, h = 0, and all internal counters = 0.
- rst has priority over every input, including bit_valid on the same edge. It may assert in any state and returns the block to HUNT the next cycle.
- Single flipped bit while LOCKED: produces 1 + popcount(TAPS) mismatches (5 with the default TAPS), as the bad bit is compared directly and then passes each tap position.
- Only Fibonacci-order streams are supported. A Galois generator must be checked using its equivalent Fibonacci TAPS.

Decomposition:
- lfsr_pkg holds:
  - sync_state_t enum {HUNT, VERIFY, LOCKED}
  - FIBONACCI/GALOIS and CONVENTIONAL/EXTENDED constants shared with the generator
  - popcount function for TAPS
- One combinational sub-module, lfsr_predict (inputs history and TAPS, output pred), shared with future generator/checker variants.

Test Plan:
- Reset: generator (LENGTH 8, TAPS 8'b01110001, seed 8'd1) drives bit_in with bit_valid continuously high. Expect state = HUNT for 8 bits, VERIFY for bits 9-24, locked = 1 in the cycle after bit 24, and err_count = 0 after 10000 bits.
- Single error: after lock, invert one bit. Expect exactly 5 err_pulse cycles, err_count = 5, and locked held high.
- Burst: invert 2 bits 20 positions apart within one window. Expect 10 mismatches; at the 8th, state -> HUNT, locked = 0, err_count = 8. After a further 24 clean bits, relock.
- Stuck line: bit_in = 0 for 200 bits with EXTEND=0. Expect locked never rises. Repeat with EXTEND=1: locked = 1 after 24 bits.
- Gaps: bit_valid toggled pseudo-randomly 50%. Expect the same lock point measured in valid bits and err_pulse = 0 on every invalid cycle.
- Control priority: assert clear_cnt on the same cycle as an error (err_count -> 0). Assert rst mid-LOCKED with bit_valid high: next cycle state = HUNT and all outputs at reset values.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and constants for the LFSR generator/checker family
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  localparam bit FIBONACCI    = 1'b0;
  localparam bit GALOIS       = 1'b1;
  localparam bit CONVENTIONAL = 1'b0;
  localparam bit EXTENDED     = 1'b1;

  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_predict.sv
// rtl/lfsr_predict.sv - Fibonacci next-bit prediction from a history vector (hist[0] newest)
module lfsr_predict #(
  parameter int                LENGTH = 8,
  parameter logic [0:LENGTH-1] TAPS   = 8'b01110001
) (
  input  logic [0:LENGTH-1] hist,
  output logic              pred
);

  always_comb begin
    pred = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      if (TAPS[i]) pred = pred ^ hist[i];
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// rtl/lfsr_checker.sv - self-synchronising serial PRBS checker with lock tracking and error count
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int                LENGTH      = 8,
  parameter logic [0:LENGTH-1] TAPS        = 8'b01110001,
  parameter int                EXTEND      = 0,
  parameter int                LOCK_COUNT  = 16,
  parameter int                WINDOW      = 64,
  parameter int                UNLOCK_ERRS = 8,
  parameter int                CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output sync_state_t      state
);

  localparam int FILL_W  = $clog2(LENGTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WBITS_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST   = FILL_W'(LENGTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WBITS_W-1:0] WBITS_LAST  = WBITS_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  UNLOCK_LAST = WERR_W'(UNLOCK_ERRS - 1);

  logic [0:LENGTH-1]  h_q, h_d;
  sync_state_t        state_q, state_d;
  logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic [WBITS_W-1:0] win_bits_q, win_bits_d;
  logic [WERR_W-1:0]  win_err_q, win_err_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;

  logic pred;
  logic match;

  lfsr_predict #(
    .LENGTH (LENGTH),
    .TAPS   (TAPS)
  ) u_predict (
    .hist (h_q),
    .pred (pred)
  );

  assign match = (bit_in == pred);

  always_comb begin
    h_d         = h_q;
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bits_d  = win_bits_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (bit_valid) begin
      h_d = {bit_in, h_q[0:LENGTH-2]};
      case (state_q)
        HUNT: begin
          if (fill_cnt_q == FILL_LAST) begin
            state_d     = VERIFY;
            fill_cnt_d  = '0;
            match_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          if (!match) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == MATCH_LAST) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            win_bits_d  = '0;
            win_err_d   = '0;
          end else begin
            match_cnt_d = match_cnt_q + MATCH_W'(1);
          end
          // An all-zero history is a dead line, never a valid sequence point.
          if (EXTEND == 0 && h_d == '0) begin
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end
        LOCKED: begin
          if (!match) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
          end
          if (!match && win_err_q == UNLOCK_LAST) begin
            state_d    = HUNT;
            fill_cnt_d = '0;
            win_bits_d = '0;
            win_err_d  = '0;
          end else if (win_bits_q == WBITS_LAST) begin
            win_bits_d = '0;
            win_err_d  = '0;
          end else begin
            win_bits_d = win_bits_q + WBITS_W'(1);
            if (!match) win_err_d = win_err_q + WERR_W'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (clear_cnt) err_count_d = '0;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q         <= '0;
      state_q     <= HUNT;
      fill_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      h_q         <= h_d;
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bits_q  <= win_bits_d;
      win_err_q   <= win_err_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb/tb_lfsr_checker.sv - directed bench for lfsr_checker against a Fibonacci generator model
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam logic [0:7] GEN_TAPS = 8'b01110001;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_cnt;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_count;
  sync_state_t state;
  logic        locked_x;
  logic        err_pulse_x;
  logic [31:0] err_count_x;
  sync_state_t state_x;

  int n_checks;
  int n_fail;

  logic [0:7] g;

  lfsr_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state     (state)
  );

  lfsr_checker #(.EXTEND(1)) dut_ext (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_cnt (clear_cnt),
    .locked    (locked_x),
    .err_pulse (err_pulse_x),
    .err_count (err_count_x),
    .state     (state_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic gen_bit(output logic b);
    b = ^(g & GEN_TAPS);
    g = {b, g[0:6]};
  endtask

  task automatic step(input logic b, input logic v, input logic clr, input logic r);
    bit_in    = b;
    bit_valid = v;
    clear_cnt = clr;
    rst       = r;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b;
    logic        v;
    sync_state_t exp_st;
    int          since_lock;
    int          pulses;
    int          hunt_at;
    int          nv;
    int          cyc;
    logic        ever;

    n_checks  = 0;
    n_fail    = 0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    clear_cnt = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", state, HUNT);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    check_eq("rst_err_count", err_count, 0);
    rst = 1'b0;

    // acquisition from a seed-1 generator
    g = 8'd1;
    for (int k = 1; k <= 24; k++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
      exp_st = (k < 8) ? HUNT : ((k < 24) ? VERIFY : LOCKED);
      check_eq("acq_state", state, exp_st);
      check_eq("acq_locked", locked, (k == 24) ? 32'd1 : 32'd0);
    end
    since_lock = 0;

    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
      since_lock++;
      if (err_pulse) pulses++;
    end
    check_eq("clean_pulses", pulses, 0);
    check_eq("clean_err_count", err_count, 0);
    check_eq("clean_locked", locked, 1);

    // single inverted bit
    ever = 1'b0;
    gen_bit(b);
    step(~b, 1'b1, 1'b0, 1'b0);
    since_lock++;
    pulses = err_pulse ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
      since_lock++;
      if (err_pulse) pulses++;
      if (!locked) ever = 1'b1;
    end
    check_eq("single_pulses", pulses, 5);
    check_eq("single_err_count", err_count, 5);
    check_eq("single_lock_dropped", ever, 0);

    // two inversions 20 bits apart inside one window
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("clear_err_count", err_count, 0);
    check_eq("idle_err_pulse", err_pulse, 0);
    for (int i = 0; i < 64; i++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
      since_lock++;
    end
    while (since_lock % 64 != 2) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
      since_lock++;
    end
    pulses  = 0;
    hunt_at = -1;
    for (int j = 0; j < 24; j++) begin
      gen_bit(b);
      if (j == 0 || j == 20) b = ~b;
      step(b, 1'b1, 1'b0, 1'b0);
      if (err_pulse) pulses++;
      if (pulses == 8 && hunt_at < 0) begin
        hunt_at = j;
        check_eq("burst_state", state, HUNT);
        check_eq("burst_locked", locked, 0);
        check_eq("burst_err_count", err_count, 8);
      end
    end
    check_eq("burst_unlock_bit", hunt_at, 23);
    check_eq("burst_pulses", pulses, 8);
    for (int k = 1; k <= 24; k++) begin
      gen_bit(b);
      step(b, 1'b1, 1'b0, 1'b0);
      if (err_pulse) pulses++;
      if (k == 23) check_eq("relock_early", locked, 0);
    end
    check_eq("relock_locked", locked, 1);
    check_eq("relock_pulses", pulses, 8);

    // stuck-at-0 line
    step(1'b0, 1'b0, 1'b0, 1'b1);
    ever = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (locked) ever = 1'b1;
      if (k == 23) check_eq("stuck_ext_early", locked_x, 0);
      if (k == 24) check_eq("stuck_ext_locked", locked_x, 1);
    end
    check_eq("stuck_never_locked", ever, 0);
    check_eq("stuck_state", state, VERIFY);

    // gappy bit_valid with garbage on idle cycles
    step(1'b0, 1'b0, 1'b0, 1'b1);
    g   = 8'd1;
    nv  = 0;
    cyc = 0;
    while (nv < 24 && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      if (v) gen_bit(b);
      else b = 1'($urandom_range(0, 1));
      step(b, v, 1'b0, 1'b0);
      cyc++;
      if (!v) check_eq("gap_idle_pulse", err_pulse, 0);
      else begin
        nv++;
        if (nv == 23) check_eq("gap_early_locked", locked, 0);
      end
    end
    check_eq("gap_valid_bits", nv, 24);
    check_eq("gap_locked", locked, 1);
    for (int i = 0; i < 100; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) gen_bit(b);
      else b = 1'($urandom_range(0, 1));
      step(b, v, 1'b0, 1'b0);
      if (err_pulse) check_eq("gap_locked_pulse", err_pulse, 0);
    end
    check_eq("gap_err_count", err_count, 0);
    check_eq("gap_hold_locked", locked, 1);

    // clear_cnt and rst priority
    gen_bit(b);
    step(~b, 1'b1, 1'b0, 1'b0);
    check_eq("flip_err_count", err_count, 1);
    gen_bit(b);
    step(b, 1'b1, 1'b0, 1'b0);
    check_eq("flip_quiet_pulse", err_pulse, 0);
    gen_bit(b);
    step(b, 1'b1, 1'b1, 1'b0);
    check_eq("clr_err_pulse", err_pulse, 1);
    check_eq("clr_err_count", err_count, 0);
    gen_bit(b);
    step(b, 1'b1, 1'b0, 1'b0);
    check_eq("post_clr_count", err_count, 1);
    gen_bit(b);
    step(b, 1'b1, 1'b0, 1'b1);
    check_eq("mid_rst_state", state, HUNT);
    check_eq("mid_rst_locked", locked, 0);
    check_eq("mid_rst_pulse", err_pulse, 0);
    check_eq("mid_rst_count", err_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
